// File: rtl/multiplier_seq_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
//   state_t   : FSM encodings (IDLE=0, RUN=1, DONE=2)
//   DEF_WIDTH : default operand width
package multiplier_seq_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/shift_add_step.sv
// One shift-add iteration (combinational).
//   acc      in  2*WIDTH  running partial-product sum
//   mcand    in  WIDTH    multiplicand (unsigned magnitude)
//   mbit     in  1        current multiplier bit
//   cnt      in  CW       bit position / shift amount
//   acc_nxt  out 2*WIDTH  acc + (mbit ? mcand<<cnt : 0)
module shift_add_step #(
  parameter int WIDTH = 4,
  parameter int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   mcand,
  input  logic               mbit,
  input  logic [CW-1:0]      cnt,
  output logic [2*WIDTH-1:0] acc_nxt
);

  logic [2*WIDTH-1:0] pp;

  always_comb begin
    pp      = {{WIDTH{1'b0}}, mcand} << cnt;
    acc_nxt = mbit ? acc + pp : acc;
  end

endmodule

// File: rtl/multiplier_seq.sv
// Sequential shift-add multiplier: one partial product per clock.
// A start accepted in IDLE or DONE captures a/b; WIDTH RUN cycles follow,
// then one DONE cycle with done=1 and out loaded. out holds until the next
// accepted start completes.
//   clk    in  1        rising-edge clock
//   rst_n  in  1        asynchronous active-low reset
//   start  in  1        request, sampled only in IDLE or DONE
//   a, b   in  WIDTH    operands, captured on accepted start
//   busy   out 1        high in RUN
//   done   out 1        one-cycle pulse in DONE
//   out    out 2*WIDTH  product
// Build option: define MULT_SIGNED_EN for two's-complement a/b/out.
module multiplier_seq
  import multiplier_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int PW = 2 * WIDTH;

  state_t          state, state_nxt;
  logic [WIDTH-1:0] mcand, mplier;
  logic [PW-1:0]    acc, acc_step;
  logic [CW-1:0]    cnt;
  logic             last, accept;
  logic [WIDTH-1:0] a_cap, b_cap;
  logic [PW-1:0]    res;

  shift_add_step #(.WIDTH(WIDTH), .CW(CW)) u_step (
    .acc     (acc),
    .mcand   (mcand),
    .mbit    (mplier[0]),
    .cnt     (cnt),
    .acc_nxt (acc_step)
  );

`ifdef MULT_SIGNED_EN
  logic sign;

  // -2^(WIDTH-1) negates to itself, which read unsigned is the correct
  // magnitude, so no extra bit is needed.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + 1'b1) : v;
  endfunction

  always_comb begin
    a_cap = mag(a);
    b_cap = mag(b);
    res   = sign ? (~acc_step + 1'b1) : acc_step;
  end
`else
  always_comb begin
    a_cap = a;
    b_cap = b;
    res   = acc_step;
  end
`endif

  always_comb begin
    last   = (cnt == CW'(WIDTH - 1));
    accept = start && (state == ST_IDLE || state == ST_DONE);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN:  if (last)  state_nxt = ST_DONE;
      ST_DONE: state_nxt = start ? ST_RUN : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ST_RUN);
    done = (state == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      out    <= '0;
`ifdef MULT_SIGNED_EN
      sign   <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (accept) begin
        mcand  <= a_cap;
        mplier <= b_cap;
        acc    <= '0;
        cnt    <= '0;
`ifdef MULT_SIGNED_EN
        sign   <= a[WIDTH-1] ^ b[WIDTH-1];
`endif
      end else if (state == ST_RUN) begin
        acc    <= acc_step;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
        // out only moves on the final add; it keeps the old product during RUN
        if (last) out <= res;
      end
    end
  end

endmodule

// File: tb/tb_multiplier_seq.sv
module tb_multiplier_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, busy, done;
  logic [3:0]  a, b;
  logic [7:0]  out;
  logic        start8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] out8;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  multiplier_seq #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .out(out)
  );

  multiplier_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .out(out8)
  );

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] p;
  } vec_t;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endfunction

  // Reference product from plain integer arithmetic.
  function automatic logic [7:0] ref4(input logic [3:0] x, input logic [3:0] y);
    int p;
`ifdef MULT_SIGNED_EN
    p = int'($signed(x)) * int'($signed(y));
`else
    p = int'(x) * int'(y);
`endif
    return p[7:0];
  endfunction

  function automatic logic [15:0] ref8(input logic [7:0] x, input logic [7:0] y);
    int p;
`ifdef MULT_SIGNED_EN
    p = int'($signed(x)) * int'($signed(y));
`else
    p = int'(x) * int'(y);
`endif
    return p[15:0];
  endfunction

  // One isolated operation: start lives in cycle 0, done expected in cycle 5,
  // busy for cycles 1..4. Operands are scrambled after capture.
  task automatic op4(input logic [3:0] aa, input logic [3:0] bb, input logic [7:0] exp, input string nm);
    int lat, bn;
    @(negedge clk); a = aa; b = bb; start = 1'b1;
    @(negedge clk); start = 1'b0; a = ~aa; b = ~bb;
    lat = 1; bn = 0;
    while (!done && lat < 20) begin
      if (busy) bn++;
      @(negedge clk); lat++;
    end
    check({nm, " latency"}, lat, 5);
    check({nm, " busy cycles"}, bn, 4);
    check({nm, " out"}, {24'd0, out}, {24'd0, exp});
    check({nm, " busy with done"}, {31'd0, busy}, 0);
    @(negedge clk);
    check({nm, " done width"}, {31'd0, done}, 0);
  endtask

  task automatic op8(input logic [7:0] aa, input logic [7:0] bb, input string nm);
    int lat;
    @(negedge clk); a8 = aa; b8 = bb; start8 = 1'b1;
    @(negedge clk); start8 = 1'b0; a8 = $urandom; b8 = $urandom;
    lat = 1;
    while (!done8 && lat < 30) begin
      @(negedge clk); lat++;
    end
    check({nm, " latency"}, lat, 9);
    check({nm, " out"}, {16'd0, out8}, {16'd0, ref8(aa, bb)});
  endtask

  vec_t vecs[6];

  initial begin : main
    int ndone, dcyc;
    logic [7:0] got, last_p;
    logic [3:0] ra, rb;

`ifdef MULT_SIGNED_EN
    vecs[0] = '{4'hD, 4'd5, 8'hF1};   // -3 * 5 = -15
    vecs[1] = '{4'h8, 4'h8, 8'd64};   // -8 * -8
    vecs[2] = '{4'd7, 4'h8, 8'hC8};   // 7 * -8 = -56
    vecs[3] = '{4'hF, 4'hF, 8'd1};    // -1 * -1
    vecs[4] = '{4'd2, 4'd1, 8'd2};
    vecs[5] = '{4'd0, 4'd9, 8'd0};    // 0 * -7
`else
    vecs[0] = '{4'd2,  4'd1,  8'd2};
    vecs[1] = '{4'd15, 4'd15, 8'd225};
    vecs[2] = '{4'd0,  4'd9,  8'd0};
    vecs[3] = '{4'd8,  4'd2,  8'd16};
    vecs[4] = '{4'd15, 4'd1,  8'd15};
    vecs[5] = '{4'd13, 4'd11, 8'd143};
`endif

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    start8 = 1'b0; a8 = '0; b8 = '0;
    repeat (2) @(negedge clk);
    check("reset busy", {31'd0, busy}, 0);
    check("reset done", {31'd0, done}, 0);
    check("reset out", {24'd0, out}, 0);
    check("reset out8", {16'd0, out8}, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) op4(vecs[i].a, vecs[i].b, vecs[i].p, $sformatf("vec%0d", i));
    last_p = vecs[5].p;

    // operand changes while idle do nothing
    a = 4'd9; b = 4'd7;
    repeat (3) @(negedge clk);
    check("idle hold out", {24'd0, out}, {24'd0, last_p});
    check("idle no done", {31'd0, done}, 0);

    // start held through RUN with different operands
    @(negedge clk); a = 4'd3; b = 4'd4; start = 1'b1;
    @(negedge clk); a = 4'd7; b = 4'd7;
    ndone = 0; dcyc = 0; got = '0;
    for (int c = 1; c <= 10; c++) begin
      if (c == 4) start = 1'b0;
      if (done) begin ndone++; dcyc = c; got = out; end
      @(negedge clk);
    end
    check("held start dones", ndone, 1);
    check("held start cycle", dcyc, 5);
    check("held start out", {24'd0, got}, 12);

    // back-to-back: new start in the DONE cycle
    @(negedge clk); a = 4'd2; b = 4'd3; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    check("b2b first done", {31'd0, done}, 1);
    check("b2b first out", {24'd0, out}, 6);
    a = 4'd5; b = 4'd6; start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("b2b busy", {31'd0, busy}, 1);
    check("b2b out held", {24'd0, out}, 6);
    repeat (3) @(negedge clk);
    check("b2b no early done", {31'd0, done}, 0);
    @(negedge clk);
    check("b2b second done", {31'd0, done}, 1);
    check("b2b second out", {24'd0, out}, 30);
    @(negedge clk);

    // reset two cycles into RUN
    @(negedge clk); a = 4'd7; b = 4'd7; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    check("pre-reset busy", {31'd0, busy}, 1);
    rst_n = 1'b0;
    #1;
    check("mid-run reset busy", {31'd0, busy}, 0);
    check("mid-run reset done", {31'd0, done}, 0);
    check("mid-run reset out", {24'd0, out}, 0);
    @(negedge clk); rst_n = 1'b1;
    op4(4'd3, 4'd3, 8'd9, "post-reset");

    // random sweeps against the arithmetic model
    for (int i = 0; i < 10; i++) begin
      ra = 4'($urandom); rb = 4'($urandom);
      op4(ra, rb, ref4(ra, rb), $sformatf("rnd4_%0d", i));
    end
    op8(8'h80, 8'h80, "w8 corner min");
    op8(8'hFF, 8'hFF, "w8 corner max");
    for (int i = 0; i < 30; i++) op8(8'($urandom), 8'($urandom), $sformatf("rnd8_%0d", i));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
